memory_responder: RTL and testbench

- Memory-side responder for the datapath's MAR/MDR memory interface.
- Accepts read and write strobes from the control unit and serves them from an internal word-addressed RAM after a configurable number of wait states.
- Returns read data on Mdataout, which connects to the datapath's Mdatain / MDR load path.
- Signals completion with a one-cycle MemDone pulse, so the control unit can stall memory steps until the access finishes.

---
 rtl/memory_responder.sv | 138 +++++++++++++
 tb/tb_memory_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: memory-side responder for the MAR/MDR memory interface.
// Serves read/write strobes from an internal word-addressed RAM after WAIT_STATES
// wait cycles and signals completion with a one-cycle MemDone pulse.
//
// Optional feature: define MEM_BOUNDS_CHECK_EN to flag addresses with any bit set
// above ADDR_WIDTH (AddrErr). Without it, upper address bits are ignored (wrap).
//
// Ports:
//   clock     - system clock, rising edge
//   clear     - asynchronous active-low reset
//   Read      - read request (level)
//   Write     - write request (level), loses to Read when both are high
//   MAR_addr  - word address from the MAR
//   MDR_data  - write data from the MDR
//   Mdataout  - read data to the datapath's Mdatain
//   MemDone   - one-cycle completion pulse
//   Busy      - high in every state except idle
//   AddrErr   - out-of-range flag during MemDone (MEM_BOUNDS_CHECK_EN only)
module memory_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 9,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           MAR_addr,
  input  logic [DATA_WIDTH-1:0] MDR_data,
  output logic [DATA_WIDTH-1:0] Mdataout,
  output logic                  MemDone,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic                  AddrErr,
`endif
  output logic                  Busy
);

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StDone, StRelease} state_e;

  localparam logic [3:0] CntLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    op_rd_q;
  logic                    addr_bad;
  logic                    req;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign req = Read | Write;

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_q;
  assign addr_bad = err_q;
`else
  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_upper;
  assign unused_upper = ^MAR_addr[31:ADDR_WIDTH];
  assign addr_bad     = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) state_d = (WAIT_STATES > 0) ? StWait : StAccess;
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StAccess;
      end
      StAccess: state_d = StDone;
      // A strobe still held after completion parks in release so it cannot re-trigger.
      StDone, StRelease: state_d = req ? StRelease : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture, wait counter and read-data register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      op_rd_q <= 1'b0;
      dout_q  <= '0;
`ifdef MEM_BOUNDS_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      if (state_q == StIdle && req) begin
        cnt_q   <= CntLoad;
        addr_q  <= MAR_addr[ADDR_WIDTH-1:0];
        data_q  <= MDR_data;
        op_rd_q <= Read;
`ifdef MEM_BOUNDS_CHECK_EN
        err_q   <= |MAR_addr[31:ADDR_WIDTH];
`endif
      end
      if (state_q == StWait && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == StAccess && op_rd_q) begin
        dout_q <= addr_bad ? '0 : mem[addr_q];
      end
    end
  end

  // RAM write port; contents are not affected by reset.
  always_ff @(posedge clock) begin
    if (state_q == StAccess && !op_rd_q && !addr_bad) begin
      mem[addr_q] <= data_q;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    Mdataout = dout_q;
    MemDone  = (state_q == StDone);
    Busy     = (state_q != StIdle);
`ifdef MEM_BOUNDS_CHECK_EN
    AddrErr  = (state_q == StDone) && err_q;
`endif
  end

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder. Three instances (WAIT_STATES = 1, 0, 15)
// share clock, reset and address/data buses; each has its own strobes. A request-age
// model predicts MemDone, Busy, Mdataout (and AddrErr) every cycle.
module tb_memory_responder;

  localparam int NI = 3;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit Bounds = 1'b1;
`else
  localparam bit Bounds = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [2:0]  rd, wr;
  logic [31:0] mar, mdr;
  logic [2:0]  done, busy, aerr;
  logic [31:0] dout [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  function automatic int ws(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  memory_responder #(.WAIT_STATES(1)) u_ws1 (
    .clock(clock), .clear(clear), .Read(rd[0]), .Write(wr[0]),
    .MAR_addr(mar), .MDR_data(mdr), .Mdataout(dout[0]), .MemDone(done[0]),
`ifdef MEM_BOUNDS_CHECK_EN
    .AddrErr(aerr[0]),
`endif
    .Busy(busy[0])
  );

  memory_responder #(.WAIT_STATES(0)) u_ws0 (
    .clock(clock), .clear(clear), .Read(rd[1]), .Write(wr[1]),
    .MAR_addr(mar), .MDR_data(mdr), .Mdataout(dout[1]), .MemDone(done[1]),
`ifdef MEM_BOUNDS_CHECK_EN
    .AddrErr(aerr[1]),
`endif
    .Busy(busy[1])
  );

  memory_responder #(.WAIT_STATES(15)) u_ws15 (
    .clock(clock), .clear(clear), .Read(rd[2]), .Write(wr[2]),
    .MAR_addr(mar), .MDR_data(mdr), .Mdataout(dout[2]), .MemDone(done[2]),
`ifdef MEM_BOUNDS_CHECK_EN
    .AddrErr(aerr[2]),
`endif
    .Busy(busy[2])
  );

`ifndef MEM_BOUNDS_CHECK_EN
  assign aerr = 3'b000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: age counts edges since acceptance (-1 = idle). The access happens on the
  // edge that makes age WS+1, which is also the single MemDone cycle; from then on
  // the request retires on the first edge with both strobes low.
  int          age   [NI] = '{-1, -1, -1};
  logic        op_m  [NI];
  logic        err_m [NI];
  logic [31:0] la    [NI];
  logic [31:0] ld    [NI];
  logic [31:0] exp_q [NI] = '{32'h0, 32'h0, 32'h0};
  logic [31:0] mm    [NI][512];

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NI; i++) begin
        age[i]   <= -1;
        exp_q[i] <= 32'h0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (age[i] < 0) begin
          if (rd[i] || wr[i]) begin
            age[i]   <= 0;
            op_m[i]  <= rd[i];
            la[i]    <= mar;
            ld[i]    <= mdr;
            err_m[i] <= Bounds && (mar[31:9] != 23'h0);
          end
        end else if (age[i] <= ws(i)) begin
          age[i] <= age[i] + 1;
          if (age[i] == ws(i)) begin
            if (op_m[i]) exp_q[i] <= err_m[i] ? 32'h0 : mm[i][la[i][8:0]];
            else if (!err_m[i]) mm[i][la[i][8:0]] <= ld[i];
          end
        end else if (!(rd[i] || wr[i])) begin
          age[i] <= -1;
        end else begin
          age[i] <= age[i] + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("memdone[%0d]", i), {31'b0, done[i]}, {31'b0, age[i] == ws(i) + 1});
      chk($sformatf("busy[%0d]", i), {31'b0, busy[i]}, {31'b0, age[i] >= 0});
      chk($sformatf("mdataout[%0d]", i), dout[i], exp_q[i]);
`ifdef MEM_BOUNDS_CHECK_EN
      chk($sformatf("addrerr[%0d]", i), {31'b0, aerr[i]},
          {31'b0, (age[i] == ws(i) + 1) && err_m[i]});
`endif
    end
  end

  // Issue one request at a negedge; drop the strobes in the MemDone cycle.
  task automatic req(input int i, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int lat, output int bcnt,
                     output logic [31:0] data_seen, output logic err_seen);
    rd[i] = r;
    wr[i] = w;
    mar   = a;
    mdr   = d;
    lat   = 0;
    bcnt  = 0;
    do begin
      @(negedge clock);
      lat++;
      if (busy[i]) bcnt++;
      mar = $urandom;   // late bus changes must not affect the accepted request
      mdr = $urandom;
    end while (!done[i] && lat < 40);
    chk($sformatf("timeout[%0d]", i), {31'b0, done[i]}, 32'd1);
    data_seen = dout[i];
    err_seen  = aerr[i];
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    @(negedge clock);
    chk($sformatf("pulse_width[%0d]", i), {31'b0, done[i]}, 32'd0);
    if (busy[i]) bcnt++;
  endtask

  logic [31:0] pre_a [4] = '{32'h0, 32'h2, 32'h7, 32'h1F};
  logic [31:0] pre_d [4] = '{32'hCAFE0000, 32'h00000222, 32'h12345678, 32'h1F1F1F1F};

  initial begin
    int          lat, bcnt, pulses;
    logic [31:0] dat;
    logic        er;
    rd  = 3'b000;
    wr  = 3'b000;
    mar = 32'h0;
    mdr = 32'h0;

    // Reset held with a write strobe high: outputs stay at reset values.
    #1 clear = 1'b0;
    wr[0] = 1'b1;
    mdr   = 32'h11111111;
    repeat (2) @(negedge clock);
    chk("reset_busy", {31'b0, busy[0]}, 32'd0);
    chk("reset_memdone", {31'b0, done[0]}, 32'd0);
    chk("reset_mdataout", dout[0], 32'h0);
    wr[0] = 1'b0;
    clear = 1'b1;
    @(negedge clock);

    // Front-door preload of every instance.
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) req(i, 1'b0, 1'b1, pre_a[k], pre_d[k], lat, bcnt, dat, er);
    end

    // Reset while a write sits in WAIT: the write must be aborted.
    wr[0] = 1'b1;
    mar   = 32'h0;
    mdr   = 32'h11111111;
    @(negedge clock);
    #1 clear = 1'b0;
    @(negedge clock);
    chk("abort_busy", {31'b0, busy[0]}, 32'd0);
    wr[0] = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, bcnt, dat, er);
    chk("abort_ram0", dat, 32'hCAFE0000);

    // Write then read at WAIT_STATES = 1.
    req(0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, lat, bcnt, dat, er);
    chk("wr_latency", lat, 32'd3);
    req(0, 1'b1, 1'b0, 32'h5, 32'h0, lat, bcnt, dat, er);
    chk("rd_latency", lat, 32'd3);
    chk("rd_data", dat, 32'hDEADBEEF);
    chk("rd_busy_cycles", bcnt, 32'd3);

    // Latency extremes.
    req(1, 1'b1, 1'b0, 32'h1F, 32'h0, lat, bcnt, dat, er);
    chk("ws0_latency", lat, 32'd2);
    chk("ws0_data", dat, 32'h1F1F1F1F);
    req(2, 1'b1, 1'b0, 32'h1F, 32'h0, lat, bcnt, dat, er);
    chk("ws15_latency", lat, 32'd17);
    chk("ws15_data", dat, 32'h1F1F1F1F);

    // Held read strobe: one completion, then parked until release.
    rd[0]  = 1'b1;
    mar    = 32'h2;
    pulses = 0;
    repeat (10) begin
      @(negedge clock);
      if (done[0]) pulses++;
    end
    chk("held_pulses", pulses, 32'd1);
    chk("held_busy", {31'b0, busy[0]}, 32'd1);
    chk("held_data", dout[0], 32'h00000222);
    rd[0] = 1'b0;
    @(negedge clock);
    chk("held_release", {31'b0, busy[0]}, 32'd0);

    // Read and write together: read wins, write dropped.
    req(0, 1'b1, 1'b1, 32'h7, 32'hFFFFFFFF, lat, bcnt, dat, er);
    chk("both_data", dat, 32'h12345678);
    req(0, 1'b1, 1'b0, 32'h7, 32'h0, lat, bcnt, dat, er);
    chk("both_ram7", dat, 32'h12345678);

    // Out-of-range address 0x200.
    req(0, 1'b0, 1'b1, 32'h200, 32'hAAAA5555, lat, bcnt, dat, er);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_wr_addrerr", {31'b0, er}, 32'd1);
    req(0, 1'b1, 1'b0, 32'h200, 32'h0, lat, bcnt, dat, er);
    chk("oob_rd_addrerr", {31'b0, er}, 32'd1);
    chk("oob_rd_data", dat, 32'h0);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, bcnt, dat, er);
    chk("oob_ram0_kept", dat, 32'hCAFE0000);
    chk("inrange_addrerr", {31'b0, er}, 32'd0);
`else
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, lat, bcnt, dat, er);
    chk("wrap_ram0", dat, 32'hAAAA5555);
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
